cv32e41s_bitcnt_seq: RTL and testbench

Parametrised, sequential bit-counting unit: computes population count (cpop), count-leading-zeros (clz) or count-trailing-zeros (ctz) of a WIDTH-bit operand, processing CHUNK bits per cycle. It sits beside the ALU as a multi-cycle functional unit for Zbb-style count instructions. Operands arrive on a valid/ready request port and results leave on a valid/ready response port, trading latency for area.

---
 rtl/cv32e41s_bitcnt_seq.sv | 150 +++++++++++++++
 tb/tb_cv32e41s_bitcnt_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_bitcnt_seq.sv
// Sequential cpop/clz/ctz unit: consumes CHUNK operand bits per cycle behind valid/ready handshakes.
// Optional: define CV32E41S_BITCNT_EARLY_EXIT_EN to let clz/ctz finish at the first nonzero chunk.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready_o=1, waiting for a request
//   BUSY  | consuming one CHUNK per cycle into the accumulator
//   DONE  | valid_o=1, result held until the consumer takes it
module cv32e41s_bitcnt_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [1:0]                     op_i,
  input  logic [WIDTH-1:0]               operand_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(WIDTH+1)-1:0]     result_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int RW = $clog2(WIDTH + 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [1:0] OP_CPOP = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CTZ  = 2'b10;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("cv32e41s_bitcnt_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shift;
  logic [WIDTH-1:0] operand_rev;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    acc_nxt;
  logic             found;
  logic             found_nxt;
  logic [CW-1:0]    cnt_left;
  logic [CHUNK-1:0] chunk;
  logic             chunk_nz;
  logic             last_chunk;
  logic             exit_early;

  function automatic logic [RW-1:0] pop_chunk(input logic [CHUNK-1:0] c);
    logic [RW-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + RW'(c[i]);
    return s;
  endfunction

  function automatic logic [RW-1:0] tz_chunk(input logic [CHUNK-1:0] c);
    logic [RW-1:0] t;
    t = RW'(CHUNK);
    for (int i = CHUNK - 1; i >= 0; i--) if (c[i]) t = RW'(i);
    return t;
  endfunction

  // clz is turned into ctz by reversing the operand once at accept time
  always_comb begin
    operand_rev = '0;
    for (int i = 0; i < WIDTH; i++) operand_rev[i] = operand_i[WIDTH-1-i];
  end

  if (N > 1) begin : g_shift
    assign shreg_shift = {{CHUNK{1'b0}}, shreg[WIDTH-1:CHUNK]};
  end else begin : g_noshift
    assign shreg_shift = '0;
  end

  assign chunk      = shreg[CHUNK-1:0];
  assign chunk_nz   = |chunk;
  assign last_chunk = (cnt_left == '0);

  always_comb begin
    acc_nxt   = acc;
    found_nxt = found;
    case (op_q)
      OP_CPOP: acc_nxt = acc + pop_chunk(chunk);
      OP_CLZ, OP_CTZ: begin
        if (!found) begin
          if (!chunk_nz) begin
            acc_nxt = acc + RW'(CHUNK);
          end else begin
            acc_nxt   = acc + tz_chunk(chunk);
            found_nxt = 1'b1;
          end
        end
      end
      default: acc_nxt = acc;
    endcase
  end

`ifdef CV32E41S_BITCNT_EARLY_EXIT_EN
  assign exit_early = ((op_q == OP_CLZ) || (op_q == OP_CTZ)) && !found && chunk_nz;
`else
  // Data-independent timing: every op walks all chunks.
  assign exit_early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      shreg    <= '0;
      acc      <= '0;
      found    <= 1'b0;
      cnt_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            op_q     <= op_i;
            shreg    <= (op_i == OP_CLZ) ? operand_rev : operand_i;
            acc      <= '0;
            found    <= 1'b0;
            cnt_left <= CW'(N - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc      <= acc_nxt;
          found    <= found_nxt;
          shreg    <= shreg_shift;
          cnt_left <= cnt_left - 1'b1;
          if (last_chunk || exit_early) state <= DONE;
        end
        DONE: begin
          if (ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state == IDLE);
  assign valid_o  = (state == DONE);
  assign result_o = acc;

endmodule

// File: tb/tb_cv32e41s_bitcnt_seq.sv
// Directed bench for cv32e41s_bitcnt_seq: default 32/8 instance plus 64/16 and 16/16 instances.
// Expected latencies follow CV32E41S_BITCNT_EARLY_EXIT_EN when the bench is built with it.
module tb_cv32e41s_bitcnt_seq;

`ifdef CV32E41S_BITCNT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v0, rdy0, vo0, ri0;
  logic [1:0]  op0;
  logic [31:0] opd0;
  logic [5:0]  res0;

  logic        v1, rdy1, vo1, ri1;
  logic [1:0]  op1;
  logic [63:0] opd1;
  logic [6:0]  res1;

  logic        v2, rdy2, vo2, ri2;
  logic [1:0]  op2;
  logic [15:0] opd2;
  logic [4:0]  res2;

  int n_cmp = 0;
  int n_bad = 0;

  cv32e41s_bitcnt_seq #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst), .valid_i(v0), .ready_o(rdy0), .op_i(op0), .operand_i(opd0),
    .valid_o(vo0), .ready_i(ri0), .result_o(res0));

  cv32e41s_bitcnt_seq #(.WIDTH(64), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst(rst), .valid_i(v1), .ready_o(rdy1), .op_i(op1), .operand_i(opd1),
    .valid_o(vo1), .ready_i(ri1), .result_o(res1));

  cv32e41s_bitcnt_seq #(.WIDTH(16), .CHUNK(16)) u_dut2 (
    .clk(clk), .rst(rst), .valid_i(v2), .ready_o(rdy2), .op_i(op2), .operand_i(opd2),
    .valid_o(vo2), .ready_i(ri2), .result_o(res2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after the accept edge; returns the latency in cycles (accept cycle counts as 1).
  task automatic wait_vo0(output int lat);
    lat = 1;
    while (!vo0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic req0(input string tag, input logic [1:0] op, input logic [31:0] opd,
                      input int exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    op0 = op; opd0 = opd; v0 = 1'b1;
    chk({tag, "_rdy"}, rdy0, 1);
    @(posedge clk); #1;
    v0 = 1'b0; op0 = 2'b00; opd0 = 32'hDEAD_BEEF;
    wait_vo0(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, res0, exp_res);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int spur;
    rst = 1'b1;
    v0 = 1'b0; op0 = '0; opd0 = '0; ri0 = 1'b1;
    v1 = 1'b0; op1 = '0; opd1 = '0; ri1 = 1'b1;
    v2 = 1'b0; op2 = '0; opd2 = '0; ri2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", rdy0, 1);
    chk("rst_valid", vo0, 0);
    chk("rst_result", res0, 0);

    req0("cpop_f0f0", 2'b00, 32'hF0F0_0001, 9, 5);
    req0("cpop_ones", 2'b00, 32'hFFFF_FFFF, 32, 5);
    req0("cpop_zero", 2'b00, 32'h0000_0000, 0, 5);
    req0("clz_bit19", 2'b01, 32'h0008_0000, 12, EE ? 3 : 5);
    req0("ctz_bit19", 2'b10, 32'h0008_0000, 19, EE ? 4 : 5);
    req0("clz_zero", 2'b01, 32'h0000_0000, 32, 5);
    req0("ctz_zero", 2'b10, 32'h0000_0000, 32, 5);
    req0("clz_8001", 2'b01, 32'h8000_0001, 0, EE ? 2 : 5);
    req0("ctz_8001", 2'b10, 32'h8000_0001, 0, EE ? 2 : 5);
    req0("ctz_0010", 2'b10, 32'h0000_0010, 4, EE ? 2 : 5);
    req0("clz_0001", 2'b01, 32'h0000_0001, 31, 5);
    req0("rsvd_op", 2'b11, 32'hFFFF_FFFF, 0, 5);

    // Reset in the middle of BUSY
    @(negedge clk);
    op0 = 2'b00; opd0 = 32'hFFFF_FFFF; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("abort_valid", vo0, 0);
    chk("abort_ready", rdy0, 1);
    chk("abort_result", res0, 0);
    spur = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (vo0) spur++;
    end
    chk("abort_spurious", spur, 0);

    // Backpressure in DONE with a competing request on the input
    @(negedge clk);
    ri0 = 1'b0; op0 = 2'b00; opd0 = 32'h0000_000F; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    wait_vo0(lat);
    chk("bp_lat", lat, 5);
    chk("bp_res", res0, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v0 = 1'b1; op0 = 2'(i % 3); opd0 = 32'h0000_0001 << (i + 3);
      @(posedge clk); #1;
      chk("bp_hold_valid", vo0, 1);
      chk("bp_hold_res", res0, 4);
      chk("bp_hold_ready", rdy0, 0);
    end
    @(negedge clk);
    op0 = 2'b10; opd0 = 32'h0000_0100; v0 = 1'b1; ri0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", vo0, 0);
    chk("bp_release_ready", rdy0, 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    wait_vo0(lat);
    chk("bp_next_lat", lat, EE ? 3 : 5);
    chk("bp_next_res", res0, 8);
    @(posedge clk); #1;

    // WIDTH=64, CHUNK=16: ctz of bit 32
    @(negedge clk);
    op1 = 2'b10; opd1 = 64'h0000_0001_0000_0000; v1 = 1'b1;
    chk("w64_rdy", rdy1, 1);
    @(posedge clk); #1;
    v1 = 1'b0;
    lat = 1;
    while (!vo1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w64_ctz_lat", lat, EE ? 4 : 5);
    chk("w64_ctz_res", res1, 32);

    // WIDTH=CHUNK=16: single-chunk path
    @(negedge clk);
    op2 = 2'b00; opd2 = 16'hAAAA; v2 = 1'b1;
    chk("w16_rdy", rdy2, 1);
    @(posedge clk); #1;
    v2 = 1'b0;
    lat = 1;
    while (!vo2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_cpop_lat", lat, 2);
    chk("w16_cpop_res", res2, 8);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
